// File: rtl/anchor_pll_supervisor_if.sv
// -----------------------------------------------------------------------------
// anchor_pll_supervisor_if
//
// Purpose : Bundles the per-channel PLL status/control signals handled by
//           anchor_pll_supervisor so the supervisor and its environment share
//           one port.
//
// Signals : pll_lock     N_PLL    raw PLL LOCKED outputs (asynchronous to clk)
//           pll_rst      N_PLL    PLL RST drives, active-high
//           clk_ce       N_PLL    BUFGCE CE drives, active-high
//           all_ready    1        registered AND of all clk_ce
//           loss_cnt     8*N_PLL  saturating lock-loss counters, ch i at [8i+7:8i]
//           timeout_flag N_PLL    sticky per-channel lock-timeout indicator
//
// Modports: master - the supervisor (reads lock, drives control/status)
//           slave  - the PLL/board side (drives lock, reads control/status)
// -----------------------------------------------------------------------------
interface anchor_pll_supervisor_if #(
    parameter int N_PLL = 2
);
    logic [N_PLL-1:0]   pll_lock;
    logic [N_PLL-1:0]   pll_rst;
    logic [N_PLL-1:0]   clk_ce;
    logic               all_ready;
    logic [8*N_PLL-1:0] loss_cnt;
    logic [N_PLL-1:0]   timeout_flag;

    modport master (
        input  pll_lock,
        output pll_rst,
        output clk_ce,
        output all_ready,
        output loss_cnt,
        output timeout_flag
    );

    modport slave (
        output pll_lock,
        input  pll_rst,
        input  clk_ce,
        input  all_ready,
        input  loss_cnt,
        input  timeout_flag
    );
endinterface

// File: rtl/anchor_pll_supervisor.sv
// -----------------------------------------------------------------------------
// anchor_pll_supervisor
//
// Purpose : Supervises N_PLL PLL channels of the anchor clocking tree from the
//           free-running board reference clock. Each channel's PLL is held in
//           reset for RST_CYCLES, its LOCKED output is synchronised and must
//           stay high for LOCK_CYCLES consecutive samples before the BUFGCE
//           enable is raised. Loss of lock while running disables the clock,
//           re-resets the PLL and bumps a saturating per-channel loss counter.
//
// Ports   : clk  - free-running supervisor clock (clk_25M domain)
//           rst  - asynchronous active-high reset
//           sup  - anchor_pll_supervisor_if.master (pll_lock in; pll_rst,
//                  clk_ce, all_ready, loss_cnt, timeout_flag out)
//
// Parameters:
//           N_PLL          channels supervised (1..8)
//           RST_CYCLES     PLL reset pulse length in clk cycles (>=1)
//           LOCK_CYCLES    consecutive lock-high samples to qualify (>=1)
//           TIMEOUT_CYCLES max cycles in WAIT before re-reset (>=LOCK_CYCLES+1)
//
// Build option:
//           ANCHOR_PLLSUP_TIMEOUT_EN - when defined, a channel stuck in WAIT
//           for TIMEOUT_CYCLES without qualifying lock is re-reset and its
//           sticky timeout_flag bit is set. When undefined, WAIT waits
//           indefinitely and timeout_flag is tied to 0.
// -----------------------------------------------------------------------------
module anchor_pll_supervisor #(
    parameter int N_PLL          = 2,
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    anchor_pll_supervisor_if.master sup
);

    // One counter width covers every interval a channel ever has to measure.
    localparam int MAX_RL     = (RST_CYCLES > LOCK_CYCLES) ? RST_CYCLES : LOCK_CYCLES;
    localparam int MAX_CYCLES = (MAX_RL > TIMEOUT_CYCLES) ? MAX_RL : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
`ifdef ANCHOR_PLLSUP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Two-stage synchroniser for the asynchronous LOCKED inputs.
    logic [N_PLL-1:0] sync1_q,  sync1_d;
    logic [N_PLL-1:0] lock_s_q, lock_s_d;

    // Per-channel FSM state and its reset/lock interval counter.
    state_e           state_q [N_PLL];
    state_e           state_d [N_PLL];
    logic [CNT_W-1:0] cnt_q   [N_PLL];
    logic [CNT_W-1:0] cnt_d   [N_PLL];
    logic [7:0]       loss_q  [N_PLL];
    logic [7:0]       loss_d  [N_PLL];

    // Registered outputs.
    logic [N_PLL-1:0] pll_rst_q, pll_rst_d;
    logic [N_PLL-1:0] clk_ce_q,  clk_ce_d;
    logic             all_ready_q, all_ready_d;

`ifdef ANCHOR_PLLSUP_TIMEOUT_EN
    // Cycles spent in WAIT since entry, independent of lock glitches.
    logic [CNT_W-1:0] tcnt_q  [N_PLL];
    logic [CNT_W-1:0] tcnt_d  [N_PLL];
    logic [N_PLL-1:0] tmo_q, tmo_d;
`endif

    logic [8*N_PLL-1:0] loss_flat;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would infer a latch.
        sync1_d   = sup.pll_lock;
        lock_s_d  = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        loss_d    = loss_q;
        pll_rst_d = '0;
        clk_ce_d  = '0;
`ifdef ANCHOR_PLLSUP_TIMEOUT_EN
        tmo_d     = tmo_q;
        for (int i = 0; i < N_PLL; i++) begin
            tcnt_d[i] = '0;
        end
`endif

        for (int i = 0; i < N_PLL; i++) begin
            case (state_q[i])
                ST_RESET: begin
                    if (cnt_q[i] == RST_LAST) begin
                        state_d[i] = ST_WAIT;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end

                ST_WAIT: begin
                    // Counter tracks the current run of consecutive high
                    // samples; any low sample restarts qualification.
                    if (lock_s_q[i]) begin
                        if (cnt_q[i] == LOCK_LAST) begin
                            state_d[i] = ST_RUN;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i]   = cnt_q[i] + CNT_ONE;
                        end
                    end else begin
                        cnt_d[i] = '0;
                    end
`ifdef ANCHOR_PLLSUP_TIMEOUT_EN
                    // Qualifying on the very last allowed cycle wins over
                    // the timeout.
                    if (state_d[i] == ST_WAIT) begin
                        if (tcnt_q[i] == TMO_LAST) begin
                            state_d[i] = ST_RESET;
                            cnt_d[i]   = '0;
                            tmo_d[i]   = 1'b1;
                        end else begin
                            tcnt_d[i]  = tcnt_q[i] + CNT_ONE;
                        end
                    end
`endif
                end

                ST_RUN: begin
                    if (!lock_s_q[i]) begin
                        state_d[i] = ST_RESET;
                        cnt_d[i]   = '0;
                        if (loss_q[i] != 8'hFF) begin
                            loss_d[i] = loss_q[i] + 8'd1;
                        end
                    end
                end

                default: begin
                    state_d[i] = ST_RESET;
                    cnt_d[i]   = '0;
                end
            endcase

            // Outputs are decoded from the next state so they change on the
            // same edge as the FSM, keeping them fully registered.
            pll_rst_d[i] = (state_d[i] == ST_RESET);
            clk_ce_d[i]  = (state_d[i] == ST_RUN);
        end

        all_ready_d = &clk_ce_q;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: counters and status are all reset because rst must return
            // every output to its idle value without waiting for a clock edge.
            sync1_q     <= '0;
            lock_s_q    <= '0;
            pll_rst_q   <= '1;
            clk_ce_q    <= '0;
            all_ready_q <= 1'b0;
            for (int i = 0; i < N_PLL; i++) begin
                state_q[i] <= ST_RESET;
                cnt_q[i]   <= '0;
                loss_q[i]  <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            lock_s_q    <= lock_s_d;
            pll_rst_q   <= pll_rst_d;
            clk_ce_q    <= clk_ce_d;
            all_ready_q <= all_ready_d;
            for (int i = 0; i < N_PLL; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                loss_q[i]  <= loss_d[i];
            end
        end
    end

`ifdef ANCHOR_PLLSUP_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            for (int i = 0; i < N_PLL; i++) begin
                tcnt_q[i] <= '0;
            end
        end else begin
            tmo_q <= tmo_d;
            for (int i = 0; i < N_PLL; i++) begin
                tcnt_q[i] <= tcnt_d[i];
            end
        end
    end

    assign sup.timeout_flag = tmo_q;
`else
    assign sup.timeout_flag = '0;
`endif

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    always_comb begin
        loss_flat = '0;
        for (int i = 0; i < N_PLL; i++) begin
            loss_flat[8*i +: 8] = loss_q[i];
        end
    end

    assign sup.pll_rst   = pll_rst_q;
    assign sup.clk_ce    = clk_ce_q;
    assign sup.all_ready = all_ready_q;
    assign sup.loss_cnt  = loss_flat;

endmodule

// File: tb/tb_anchor_pll_supervisor.sv
// -----------------------------------------------------------------------------
// tb_anchor_pll_supervisor
//
// Self-checking bench for anchor_pll_supervisor (N_PLL=2, RST_CYCLES=16,
// LOCK_CYCLES=8, TIMEOUT_CYCLES=100). A reference model expresses each
// channel as deadlines and run lengths measured in clock edges and is checked
// against every output after every edge, plus directed checks on the
// documented timing points.
// -----------------------------------------------------------------------------
module tb_anchor_pll_supervisor;

    localparam int N_PLL   = 2;
    localparam int RST_C   = 16;
    localparam int LOCK_C  = 8;
    localparam int TMO_C   = 100;
`ifdef ANCHOR_PLLSUP_TIMEOUT_EN
    localparam bit TMO_EN  = 1'b1;
`else
    localparam bit TMO_EN  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    anchor_pll_supervisor_if #(.N_PLL(N_PLL)) sup_if ();

    anchor_pll_supervisor #(
        .N_PLL          (N_PLL),
        .RST_CYCLES     (RST_C),
        .LOCK_CYCLES    (LOCK_C),
        .TIMEOUT_CYCLES (TMO_C)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sup (sup_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edge index since reset release, and per channel the
    // edge at which the reset pulse ends (0 = not resetting), the edge WAIT
    // began, the current run of high samples, and the running/status values.
    int edge_n;
    int m_rst_end    [N_PLL];
    int m_wait_start [N_PLL];
    int m_hi         [N_PLL];
    int m_loss       [N_PLL];
    bit m_ce         [N_PLL];
    bit m_tflag      [N_PLL];
    bit m_raw1       [N_PLL];   // raw lock sampled one edge ago
    bit m_raw2       [N_PLL];   // raw lock sampled two edges ago
    bit m_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        edge_n  = 0;
        m_ready = 1'b0;
        for (int i = 0; i < N_PLL; i++) begin
            m_rst_end[i]    = RST_C;
            m_wait_start[i] = 0;
            m_hi[i]         = 0;
            m_loss[i]       = 0;
            m_ce[i]         = 1'b0;
            m_tflag[i]      = 1'b0;
            m_raw1[i]       = 1'b0;
            m_raw2[i]       = 1'b0;
        end
    endtask

    // Advance the model by one clock edge; v is the raw lock sampled there.
    task automatic model_edge(input logic [N_PLL-1:0] v);
        bit all_ce;
        bit s;
        edge_n++;
        all_ce = 1'b1;
        for (int i = 0; i < N_PLL; i++) all_ce = all_ce & m_ce[i];
        for (int i = 0; i < N_PLL; i++) begin
            // The decision at this edge uses the lock value two edges old.
            s         = m_raw2[i];
            m_raw2[i] = m_raw1[i];
            m_raw1[i] = v[i];
            if (m_rst_end[i] != 0) begin
                if (edge_n == m_rst_end[i]) begin
                    m_rst_end[i]    = 0;
                    m_wait_start[i] = edge_n;
                    m_hi[i]         = 0;
                end
            end else if (!m_ce[i]) begin
                m_hi[i] = s ? m_hi[i] + 1 : 0;
                if (m_hi[i] == LOCK_C) begin
                    m_ce[i] = 1'b1;
                end else if (TMO_EN && (edge_n - m_wait_start[i] == TMO_C)) begin
                    m_rst_end[i] = edge_n + RST_C;
                    m_tflag[i]   = 1'b1;
                end
            end else if (!s) begin
                m_ce[i]      = 1'b0;
                m_rst_end[i] = edge_n + RST_C;
                m_loss[i]    = (m_loss[i] < 255) ? m_loss[i] + 1 : 255;
            end
        end
        m_ready = all_ce;
    endtask

    task automatic compare_all();
        logic [N_PLL-1:0]   e_rst, e_ce, e_tf;
        logic [8*N_PLL-1:0] e_loss;
        for (int i = 0; i < N_PLL; i++) begin
            e_rst[i]          = (m_rst_end[i] != 0);
            e_ce[i]           = m_ce[i];
            e_tf[i]           = m_tflag[i];
            e_loss[8*i +: 8]  = 8'(m_loss[i]);
        end
        check("pll_rst",      32'(sup_if.pll_rst),      32'(e_rst));
        check("clk_ce",       32'(sup_if.clk_ce),       32'(e_ce));
        check("all_ready",    32'(sup_if.all_ready),    32'(m_ready));
        check("loss_cnt",     32'(sup_if.loss_cnt),     32'(e_loss));
        check("timeout_flag", 32'(sup_if.timeout_flag), 32'(e_tf));
    endtask

    // Drive one lock value, wait for the edge, then check all outputs.
    task automatic step(input logic [N_PLL-1:0] v);
        sup_if.pll_lock = v;
        @(posedge clk);
        model_edge(v);
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"},   32'(sup_if.pll_rst),      32'(2'b11));
        check({tag, "_clk_ce"},    32'(sup_if.clk_ce),       32'd0);
        check({tag, "_all_ready"}, 32'(sup_if.all_ready),    32'd0);
        check({tag, "_loss_cnt"},  32'(sup_if.loss_cnt),     32'd0);
        check({tag, "_tflag"},     32'(sup_if.timeout_flag), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [N_PLL-1:0] v;
        int               hold [N_PLL];
        int               rst_high;
        int               rises;
        logic             prev_rst0;
        logic [19:0]      pat;

        rst             = 1'b1;
        sup_if.pll_lock = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        release_reset();

        // Lock on ch0 driven after edge 20, ch1 after edge 40.
        for (int e = 1; e <= 60; e++) begin
            v[0] = (e >= 21);
            v[1] = (e >= 41);
            step(v);
            if (e == 15) check("a_rst0_e15", 32'(sup_if.pll_rst[0]), 32'd1);
            if (e == 16) check("a_rst0_e16", 32'(sup_if.pll_rst[0]), 32'd0);
            if (e == 29) check("a_ce0_e29",  32'(sup_if.clk_ce[0]),  32'd0);
            if (e == 30) check("a_ce0_e30",  32'(sup_if.clk_ce[0]),  32'd1);
            if (e == 50) check("a_rdy_e50",  32'(sup_if.all_ready),  32'd0);
            if (e == 51) check("a_rdy_e51",  32'(sup_if.all_ready),  32'd1);
        end

        // One-cycle lock drop on ch0 while running.
        for (int i = 0; i < 40; i++) begin
            v = (i == 0) ? 2'b10 : 2'b11;
            step(v);
            if (i == 1)  check("b_ce0_hold",  32'(sup_if.clk_ce[0]),  32'd1);
            if (i == 2)  check("b_ce0_fall",  32'(sup_if.clk_ce[0]),  32'd0);
            if (i == 2)  check("b_rst0_rise", 32'(sup_if.pll_rst[0]), 32'd1);
            if (i == 17) check("b_rst0_hold", 32'(sup_if.pll_rst[0]), 32'd1);
            if (i == 18) check("b_rst0_fall", 32'(sup_if.pll_rst[0]), 32'd0);
        end
        check("b_loss0", 32'(sup_if.loss_cnt[7:0]), 32'd1);
        check("b_relock", 32'(sup_if.clk_ce[0]), 32'd1);

        // Park ch0 in WAIT, then glitch: 5 high, 1 low, 14 high.
        for (int i = 0; i < 30; i++) step(2'b10);
        pat      = 20'b1111_1111_1111_1101_1111;
        rst_high = 0;
        for (int i = 0; i < 20; i++) begin
            v[0] = pat[i];
            v[1] = 1'b1;
            step(v);
            if (sup_if.pll_rst[0]) rst_high++;
            if (i == 14) check("c_ce0_early", 32'(sup_if.clk_ce[0]), 32'd0);
            if (i == 15) check("c_ce0_rise",  32'(sup_if.clk_ce[0]), 32'd1);
        end
        check("c_no_rst_pulse", 32'(rst_high), 32'd0);

        // Randomised lock waveforms with mixed short glitches and long holds.
        for (int i = 0; i < N_PLL; i++) hold[i] = 0;
        v = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N_PLL; i++) begin
                if (hold[i] == 0) begin
                    v[i]    = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                                          : int'($urandom_range(1, 9));
                end
                hold[i]--;
            end
            step(v);
        end

        // Asynchronous reset while both channels run.
        for (int i = 0; i < 40; i++) step(2'b11);
        check("e_both_run", 32'(sup_if.clk_ce), 32'(2'b11));
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async");
        release_reset();

        // Lock held low: re-reset pulses only with the timeout feature.
        rises     = 0;
        prev_rst0 = sup_if.pll_rst[0];
        for (int i = 0; i < 300; i++) begin
            step(2'b00);
            if (sup_if.pll_rst[0] && !prev_rst0) rises++;
            prev_rst0 = sup_if.pll_rst[0];
        end
        check("f_rst_rises", 32'(rises),
              TMO_EN ? 32'((300 - RST_C) / (TMO_C + RST_C)) : 32'd0);
        check("f_tflag", 32'(sup_if.timeout_flag), TMO_EN ? 32'(2'b11) : 32'd0);

        // 300 lock losses on ch1 saturate its counter.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 34; i++) step(2'b11);
            step(2'b01);
        end
        for (int i = 0; i < 4; i++) step(2'b11);
        check("g_loss1_sat", 32'(sup_if.loss_cnt[15:8]), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
